// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID instruction, EX/MEM hazard info and the
// registered EX copy, forwarding selects and load-use stall outputs.
// No storage; the slave modport is the pipeline register's view.
//
// Ports (slave view):
//   in : id_* (decoded instruction), mem_rd/mem_regwrite, flush_in, hold_in
//   out: ex_* (registered copy), forward1_out/forward2_out, stall_out, stall_count
interface id_ex_stage_if #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int AW   = 4,
  parameter int CNTW = 16
);
  // ID side
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_data1;
  logic [DW-1:0] id_data2;
  logic [DW-1:0] id_imm;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic [AW-1:0] id_aluop;
  // EX/MEM snapshot and pipeline control
  logic [RW-1:0] mem_rd;
  logic          mem_regwrite;
  logic          flush_in;
  logic          hold_in;
  // EX side
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_data1;
  logic [DW-1:0] ex_data2;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_rd;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic [AW-1:0] ex_aluop;
  logic [2:0]    forward1_out;
  logic [2:0]    forward2_out;
  logic          stall_out;
  logic [CNTW-1:0] stall_count;

  modport slave (
    input  id_valid, id_pc, id_data1, id_data2, id_imm, id_rs, id_rt, id_rd,
           id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite, id_aluop,
           mem_rd, mem_regwrite, flush_in, hold_in,
    output ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
           forward1_out, forward2_out, stall_out, stall_count
  );

  modport master (
    output id_valid, id_pc, id_data1, id_data2, id_imm, id_rs, id_rt, id_rd,
           id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite, id_aluop,
           mem_rd, mem_regwrite, flush_in, hold_in,
    input  ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
           forward1_out, forward2_out, stall_out, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered forwarding selects and load-use bubble insertion.
// Latency: one cycle ID->EX; stall_out is combinational from the current EX contents.
// Backpressure: hold_in freezes every register; stall_out freezes PC and IF/ID upstream.
//
// Ports: clk (rising edge), rstn (async active-low), bus (id_ex_stage_if.slave):
//   inputs id_*, mem_rd, mem_regwrite, flush_in, hold_in;
//   outputs ex_*, forward1_out, forward2_out, stall_out, stall_count.
module id_ex_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int AW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  id_ex_stage_if.slave    bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic [AW-1:0] aluop;
    logic [2:0]    fwd1;
    logic [2:0]    fwd2;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            lu;
  logic [2:0]      fwd1_sel, fwd2_sel;

  // 2 = EX/MEM result (the instruction now in EX), 1 = MEM/WB data, 0 = register file.
  // The EX match wins because it is the younger producer; r0 never forwards.
  function automatic logic [2:0] fwd_sel(
    input logic          use_src,
    input logic [RW-1:0] src,
    input logic          ex_v,
    input logic          ex_rw,
    input logic [RW-1:0] ex_rd,
    input logic          mem_rw,
    input logic [RW-1:0] mem_rd
  );
    logic [2:0] sel;
    sel = 3'd0;
    if (use_src && ex_v && ex_rw && (ex_rd != '0) && (ex_rd == src)) begin
      sel = 3'd2;
    end else if (use_src && mem_rw && (mem_rd != '0) && (mem_rd == src)) begin
      sel = 3'd1;
    end
    return sel;
  endfunction

  always_comb begin
    // A load in EX cannot forward its data in time for a consumer in ID.
    lu = bus.id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
         ((bus.id_use_rs && (ex_q.rd == bus.id_rs)) ||
          (bus.id_use_rt && (ex_q.rd == bus.id_rt)));

    fwd1_sel = fwd_sel(bus.id_use_rs, bus.id_rs, ex_q.valid, ex_q.regwrite, ex_q.rd,
                       bus.mem_regwrite, bus.mem_rd);
    fwd2_sel = fwd_sel(bus.id_use_rt, bus.id_rt, ex_q.valid, ex_q.regwrite, ex_q.rd,
                       bus.mem_regwrite, bus.mem_rd);

    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!bus.hold_in) begin
      if (bus.flush_in) begin
        ex_d = '0;
      end else if (lu) begin
        ex_d = '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end else begin
        ex_d.valid    = bus.id_valid;
        ex_d.pc       = bus.id_pc;
        ex_d.data1    = bus.id_data1;
        ex_d.data2    = bus.id_data2;
        ex_d.imm      = bus.id_imm;
        ex_d.rs       = bus.id_rs;
        ex_d.rt       = bus.id_rt;
        ex_d.rd       = bus.id_rd;
        // An empty ID slot must not write or touch memory downstream.
        ex_d.regwrite = bus.id_valid & bus.id_regwrite;
        ex_d.memread  = bus.id_valid & bus.id_memread;
        ex_d.memwrite = bus.id_valid & bus.id_memwrite;
        ex_d.aluop    = bus.id_aluop;
        ex_d.fwd1     = fwd1_sel;
        ex_d.fwd2     = fwd2_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_data1     = ex_q.data1;
  assign bus.ex_data2     = ex_q.data2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.forward1_out = ex_q.fwd1;
  assign bus.forward2_out = ex_q.fwd2;
  // A taken branch kills the dependent instruction, so there is nothing to wait for.
  assign bus.stall_out    = lu & ~bus.flush_in;
  assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table plus hold, saturation and async-reset sequences.
// Expected EX contents are queued when a vector is driven and compared one edge later.
// A narrow stall counter keeps the saturation run short.
module tb_id_ex_stage;
  localparam int DW = 32, RW = 5, AW = 4, CNTW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .RW(RW), .AW(AW), .CNTW(CNTW)) bus ();
  id_ex_stage #(.DW(DW), .RW(RW), .AW(AW), .CNTW(CNTW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] d1, d2;
    logic [4:0]  rs, rt, rd;
    logic        urs, urt, rw, mr, mw;
    logic [4:0]  mrd;
    logic        mrw, fl;
    logic        e_stall, e_ld;
    logic [2:0]  f1, f2;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw;
    logic [3:0]  op;
    logic [2:0]  f1, f2;
    logic [7:0]  cnt;
  } ex_exp_t;

  ex_exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(string nm, logic v, logic [31:0] d1, logic [31:0] d2,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic urs, logic urt, logic rw, logic mr, logic mw,
                              logic [4:0] mrd, logic mrw, logic fl,
                              logic e_stall, logic e_ld, logic [2:0] f1, logic [2:0] f2,
                              logic [7:0] cnt);
    vec_t t;
    t.nm = nm; t.v = v; t.d1 = d1; t.d2 = d2; t.rs = rs; t.rt = rt; t.rd = rd;
    t.urs = urs; t.urt = urt; t.rw = rw; t.mr = mr; t.mw = mw;
    t.mrd = mrd; t.mrw = mrw; t.fl = fl;
    t.e_stall = e_stall; t.e_ld = e_ld; t.f1 = f1; t.f2 = f2; t.cnt = cnt;
    return t;
  endfunction

  function automatic logic [31:0] pc_of(int idx);
    return 32'h1000 + 32'(idx * 4);
  endfunction

  // Expected EX contents: loaded fields, or an all-zero bubble.
  function automatic ex_exp_t mk_exp(vec_t t, int idx);
    ex_exp_t e;
    e.nm = t.nm; e.cnt = t.cnt;
    if (t.e_ld) begin
      e.v = t.v; e.pc = pc_of(idx); e.d1 = t.d1; e.d2 = t.d2; e.imm = 32'hA0 + 32'(idx);
      e.rs = t.rs; e.rt = t.rt; e.rd = t.rd;
      e.rw = t.v & t.rw; e.mr = t.v & t.mr; e.mw = t.v & t.mw;
      e.op = 4'(idx); e.f1 = t.f1; e.f2 = t.f2;
    end else begin
      e.v = 0; e.pc = 0; e.d1 = 0; e.d2 = 0; e.imm = 0; e.rs = 0; e.rt = 0; e.rd = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.op = 0; e.f1 = 0; e.f2 = 0;
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t, int idx, logic hold);
    bus.id_valid = t.v;      bus.id_pc = pc_of(idx);
    bus.id_data1 = t.d1;     bus.id_data2 = t.d2;
    bus.id_imm = 32'hA0 + 32'(idx);
    bus.id_rs = t.rs;        bus.id_rt = t.rt;       bus.id_rd = t.rd;
    bus.id_use_rs = t.urs;   bus.id_use_rt = t.urt;
    bus.id_regwrite = t.rw;  bus.id_memread = t.mr;  bus.id_memwrite = t.mw;
    bus.id_aluop = 4'(idx);
    bus.mem_rd = t.mrd;      bus.mem_regwrite = t.mrw;
    bus.flush_in = t.fl;     bus.hold_in = hold;
  endtask

  task automatic compare_ex(ex_exp_t e);
    chk({e.nm, ".ex_valid"},    bus.ex_valid,     e.v);
    chk({e.nm, ".ex_pc"},       bus.ex_pc,        e.pc);
    chk({e.nm, ".ex_data1"},    bus.ex_data1,     e.d1);
    chk({e.nm, ".ex_data2"},    bus.ex_data2,     e.d2);
    chk({e.nm, ".ex_imm"},      bus.ex_imm,       e.imm);
    chk({e.nm, ".ex_rs"},       bus.ex_rs,        e.rs);
    chk({e.nm, ".ex_rt"},       bus.ex_rt,        e.rt);
    chk({e.nm, ".ex_rd"},       bus.ex_rd,        e.rd);
    chk({e.nm, ".ex_regwrite"}, bus.ex_regwrite,  e.rw);
    chk({e.nm, ".ex_memread"},  bus.ex_memread,   e.mr);
    chk({e.nm, ".ex_memwrite"}, bus.ex_memwrite,  e.mw);
    chk({e.nm, ".ex_aluop"},    bus.ex_aluop,     e.op);
    chk({e.nm, ".forward1"},    bus.forward1_out, e.f1);
    chk({e.nm, ".forward2"},    bus.forward2_out, e.f2);
    chk({e.nm, ".stall_count"}, bus.stall_count,  e.cnt);
  endtask

  task automatic pop_compare(string nm);
    ex_exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", nm);
    end else begin
      e = sb.pop_front();
      compare_ex(e);
    end
  endtask

  // Drive on the falling edge, check stall_out mid-low-phase, compare after the rising edge.
  task automatic apply(vec_t t, int idx, logic hold, ex_exp_t keep);
    @(negedge clk);
    drive(t, idx, hold);
    #2;
    chk({t.nm, ".stall_out"}, bus.stall_out, t.e_stall);
    if (hold) sb.push_back(keep);
    else      sb.push_back(mk_exp(t, idx));
    @(posedge clk);
    #1;
    pop_compare(t.nm);
  endtask

  task automatic check_zero(string nm);
    chk({nm, ".ex_valid"},    bus.ex_valid,     0);
    chk({nm, ".ex_pc"},       bus.ex_pc,        0);
    chk({nm, ".ex_data1"},    bus.ex_data1,     0);
    chk({nm, ".ex_data2"},    bus.ex_data2,     0);
    chk({nm, ".ex_imm"},      bus.ex_imm,       0);
    chk({nm, ".ex_rd"},       bus.ex_rd,        0);
    chk({nm, ".ex_regwrite"}, bus.ex_regwrite,  0);
    chk({nm, ".ex_memread"},  bus.ex_memread,   0);
    chk({nm, ".ex_memwrite"}, bus.ex_memwrite,  0);
    chk({nm, ".ex_aluop"},    bus.ex_aluop,     0);
    chk({nm, ".forward1"},    bus.forward1_out, 0);
    chk({nm, ".forward2"},    bus.forward2_out, 0);
    chk({nm, ".stall_count"}, bus.stall_count,  0);
    chk({nm, ".stall_out"},   bus.stall_out,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    tbl[13];
    vec_t    p, ld, dep, h;
    ex_exp_t keep, none;

    //          name           v  d1     d2     rs rt rd urs urt rw mr mw mrd mrw fl  stl ld f1 f2 cnt
    tbl[0]  = mk("plain",       1, 'h11,  'h22,  1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[1]  = mk("ex_fwd",      1, 'h33,  'h44,  3, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0,  0, 1, 2, 0, 0);
    tbl[2]  = mk("ex_over_mem", 1, 'h55,  'h66,  5, 6, 6, 1, 1, 1, 0, 0, 5, 1, 0,  0, 1, 2, 0, 0);
    tbl[3]  = mk("mem_fwd",     1, 'h77,  'h88,  9, 9, 0, 1, 1, 1, 0, 0, 9, 1, 0,  0, 1, 1, 1, 0);
    tbl[4]  = mk("rd0_never",   1, 'h99,  'haa,  0, 8, 7, 1, 1, 1, 1, 0, 8, 1, 0,  0, 1, 0, 1, 0);
    tbl[5]  = mk("lu_rt",       1, 'hbb,  'hcc,  1, 7, 8, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    tbl[6]  = mk("after_lu",    1, 'hbb,  'hcc,  1, 7, 8, 1, 1, 1, 0, 0, 7, 1, 0,  0, 1, 0, 1, 1);
    tbl[7]  = mk("use_off",     1, 'hdd,  'hee,  8, 8, 9, 0, 0, 1, 1, 0, 8, 1, 0,  0, 1, 0, 0, 1);
    tbl[8]  = mk("flush_lu",    1, 'h12,  'h34,  9, 2, 4, 1, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    tbl[9]  = mk("id_invalid",  0, 'h56,  'h78,  3, 4, 9, 0, 0, 1, 1, 1, 0, 0, 0,  0, 1, 0, 0, 1);
    tbl[10] = mk("load_r10",    1, 'h9a,  'hbc,  0, 0,10, 0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    tbl[11] = mk("lu_needs_idv",0, 'hde,  'hf0, 10, 0,11, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 1);
    tbl[12] = mk("store",       1, 'h13,  'h57,  2, 3, 0, 1, 1, 0, 0, 1, 2, 1, 0,  0, 1, 1, 0, 1);

    // Reset state, with ID presenting a would-be dependent instruction.
    rstn = 1'b0;
    drive(tbl[5], 0, 1'b0);
    #3;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    none = mk_exp(tbl[0], 0);
    foreach (tbl[i]) apply(tbl[i], i, 1'b0, none);

    // Hold for three cycles with a live load-use hazard and changing inputs.
    p = mk("prime_ld", 1, 'h21, 'h43, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    apply(p, 13, 1'b0, none);
    keep = mk_exp(p, 13);
    keep.nm = "hold";
    h = mk("hold1", 1, 'h1, 'h2, 1, 7, 8, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(h, 14, 1'b1, keep);
    h = mk("hold2", 1, 'h3, 'h4, 7, 2, 9, 1, 1, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    apply(h, 15, 1'b1, keep);
    h = mk("hold3", 1, 'h5, 'h6, 7, 7, 4, 1, 1, 0, 0, 1, 7, 1, 0, 1, 0, 0, 0, 0);
    apply(h, 16, 1'b1, keep);
    h = mk("release_lu", 1, 'h5, 'h6, 1, 7, 8, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    apply(h, 17, 1'b0, none);
    h = mk("release_go", 1, 'h5, 'h6, 1, 7, 8, 1, 1, 1, 0, 0, 7, 1, 0, 0, 1, 0, 1, 2);
    apply(h, 18, 1'b0, none);

    // Saturation: count is 2 here; 253 more stalls reach 255, further stalls must stick.
    ld  = mk("sat_ld",  1, 'h1, 'h2, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    dep = mk("sat_dep", 1, 'h3, 'h4, 7, 0, 8, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 253; k++) begin
      @(negedge clk); drive(ld, 19, 1'b0);
      @(negedge clk); drive(dep, 20, 1'b0);
    end
    @(negedge clk);
    chk("sat_reach", bus.stall_count, 8'hFF);
    for (int k = 0; k < 7; k++) begin
      drive(ld, 19, 1'b0);
      @(negedge clk); drive(dep, 20, 1'b0);
      @(negedge clk);
    end
    chk("sat_hold", bus.stall_count, 8'hFF);

    // Asynchronous reset in the middle of an active stall.
    drive(ld, 19, 1'b0);
    @(negedge clk);
    drive(dep, 20, 1'b0);
    #2;
    chk("pre_rst.stall_out", bus.stall_out, 1);
    rstn = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    check_zero("rst_held");
    rstn = 1'b1;
    h = mk("post_rst", 1, 'h3, 'h4, 7, 0, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply(h, 21, 1'b0, none);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core; sits directly upstream of the EX-stage forwarding mux.
- Latches decoded operands and control from ID and presents them to EX.
- Pre-computes the 3-bit forwarding selects (0 = register file, 1 = MEM/WB data, 2 = EX/MEM result) one cycle early, registered and aligned with the EX operands.
- Detects load-use hazards, stalls IF/ID, and inserts a bubble; also counts load-use stalls.

Parameters:
- DW, 32, operand/PC data width
- RW, 5, register index width
- AW, 4, ALU op width
- CNTW, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  instruction PC
- id_data1  in  DW  register-file read port 1
- id_data2  in  DW  register-file read port 2
- id_imm  in  DW  sign-extended immediate
- id_rs  in  RW  source 1 index
- id_rt  in  RW  source 2 index
- id_rd  in  RW  destination index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_regwrite  in  1  writes the register file
- id_memread  in  1  load instruction
- id_memwrite  in  1  store instruction
- id_aluop  in  AW  ALU operation
- mem_rd  in  RW  destination index currently in EX/MEM
- mem_regwrite  in  1  EX/MEM instruction writes the register file
- flush_in  in  1  branch/jump taken; kill the ID instruction
- hold_in  in  1  downstream stall; freeze this stage
- ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_aluop  out  as inputs  registered EX copies
- forward1_out  out  3  registered select for EX operand 1
- forward2_out  out  3  registered select for EX operand 2
- stall_out  out  1  combinational; freeze PC and IF/ID
- stall_count  out  CNTW  saturating load-use stall counter

Behaviour:
- Reset (rstn=0, async): every registered output, including stall_count, is 0. stall_out = 0 while in reset.

Load-use hazard (combinational):
- lu = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)).
- stall_out = lu & ~flush_in.

Forward select for source rs (identical logic for rt with id_use_rt/id_rt):
- 2 if id_use_rs & ex_valid & ex_regwrite & ex_rd!=0 & ex_rd==id_rs.
- else 1 if id_use_rs & mem_regwrite & mem_rd!=0 & mem_rd==id_rs.
- else 0.
- EX match has priority over MEM. Index 0 never forwards. Codes 3-7 are never produced.

Per rising edge, priority order:
1. hold_in=1: all outputs hold their values, including forward selects and stall_count; flush_in and lu are ignored.
2. flush_in=1: insert a bubble.
3. lu=1: insert a bubble and increment stall_count, saturating at all-ones.
4. Otherwise: load all ex_* from id_*, and forward1_out/forward2_out from the computed selects.

Bubble:
- ex_valid, ex_regwrite, ex_memread, ex_memwrite and both forward selects become 0.
- Data, index, PC and aluop fields become 0.

Other rules:
- id_valid=0 with no hold/flush/lu: loads normally, with ex_valid=0 and all three write/read controls forced to 0.
- Single-cycle latency ID→EX. A load-use stall costs exactly one bubble: on the next cycle the load sits in MEM and the dependent instruction loads with select 1.
- Reset asserted mid-stall clears everything at once. stall_out is re-evaluated from the cleared state.

Test Plan:
- Plain load: id_valid=1, data1=0x11, data2=0x22, rd=3, regwrite=1, no hazards -> next edge ex_data1=0x11, ex_data2=0x22, ex_rd=3, forward1_out=forward2_out=0.
- EX forward: EX holds regwrite rd=5; ID rs=5 (use_rs) -> forward1_out=2. Also set mem_rd=5, mem_regwrite=1 -> still 2. With EX rd=0 instead -> 1.
- Load-use: EX holds load rd=7; ID rt=7 (use_rt) -> stall_out=1 same cycle. Next edge: bubble (ex_valid=0, ex_regwrite=0) and stall_count=1. Following edge (mem_rd=7, mem_regwrite=1) -> instruction enters EX with forward2_out=1.
- Flush vs load-use: same hazard plus flush_in=1 -> stall_out=0, bubble inserted, stall_count unchanged.
- Hold: hold_in=1 for 3 cycles while inputs change and lu=1 -> all outputs constant and stall_count unchanged. Release -> normal priority resumes.
- Reset/saturation: drive 0xFFFF+2 load-use stalls -> stall_count stays 0xFFFF. Assert rstn=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
